// File: rtl/icache_assoc_if.sv
// Fetch-port and instruction-memory bundle for icache_assoc.
// The slave side is the cache; the master side is the datapath/memory.
interface icache_assoc_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        flush;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  modport slave (
    input  imemREN, imemaddr, flush, iload, iwait,
    output ihit, imemload, iREN, iaddr,
    output hit_count, miss_count
  );

  modport master (
    output imemREN, imemaddr, flush, iload, iwait,
    input  ihit, imemload, iREN, iaddr,
    input  hit_count, miss_count
  );
endinterface

// File: rtl/icache_assoc.sv
// Set-associative instruction cache with LRU ages,
// burst refill, flush and hit/miss counters.
module icache_assoc #(
  parameter int WAYS     = 2,
  parameter int SETS     = 8,
  parameter int BLKWORDS = 2
) (
  input  logic CLK,
  input  logic RST,
  icache_assoc_if.slave bus
);
  localparam int WB = $clog2(BLKWORDS);
  localparam int KW = (BLKWORDS > 1) ? WB : 1;
  localparam int IW = $clog2(SETS);
  localparam int AW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LO = 2 + WB + IW;
  localparam int TW = 32 - LO;

  typedef enum logic {IDLE, FILL} state_t;

  state_t        state_q;
  logic [KW-1:0] k_q;
  logic [31:0]   base_q;
  logic [AW-1:0] vic_q;
  logic [31:0]   hit_q;
  logic [31:0]   miss_q;

  logic          valid_q [WAYS][SETS];
  logic [TW-1:0] tag_q   [WAYS][SETS];
  logic [31:0]   data_q  [WAYS][SETS][BLKWORDS];
  logic [AW-1:0] age_q   [SETS][WAYS];

  logic [IW-1:0] idx, fidx, uset;
  logic [TW-1:0] tag, ftag;
  logic [KW-1:0] wsel;
  logic [AW-1:0] hway, vic, uway;
  logic          hit, lookup, last, upd;

  assign idx  = IW'(bus.imemaddr >> (2 + WB));
  assign tag  = bus.imemaddr[31:LO];
  assign wsel = KW'((bus.imemaddr >> 2) & (BLKWORDS - 1));
  assign fidx = IW'(base_q >> (2 + WB));
  assign ftag = base_q[31:LO];

  // Tag compare across the indexed set.
  always_comb begin
    hit  = 1'b0;
    hway = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[w][idx] && tag_q[w][idx] == tag) begin
        hit  = 1'b1;
        hway = AW'(w);
      end
    end
  end

  // Victim: lowest invalid way, else the oldest (age WAYS-1).
  always_comb begin
    vic = '0;
    for (int w = 0; w < WAYS; w++)
      if (age_q[idx][w] == AW'(WAYS - 1)) vic = AW'(w);
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_q[w][idx]) vic = AW'(w);
  end

  assign lookup = (state_q == IDLE) && bus.imemREN && !bus.flush;
  assign last   = (state_q == FILL) && !bus.iwait && !bus.flush
                  && (k_q == KW'(BLKWORDS - 1));

  assign bus.ihit     = lookup && hit;
  assign bus.imemload = bus.ihit ? data_q[hway][idx][wsel] : 32'h0;
  assign bus.iREN     = (state_q == FILL);
  assign bus.iaddr    = (state_q == FILL)
                        ? base_q + 32'({k_q, 2'b00})
                        : bus.imemaddr;
  assign bus.hit_count  = hit_q;
  assign bus.miss_count = miss_q;

  // A hit and a refill completion both promote one way to age 0.
  always_comb begin
    upd  = bus.ihit || last;
    uset = bus.ihit ? idx : fidx;
    uway = bus.ihit ? hway : vic_q;
  end

  // Control FSM, valid bits, ages and counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      k_q     <= '0;
      base_q  <= '0;
      vic_q   <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          valid_q[w][s] <= 1'b0;
          age_q[s][w]   <= AW'(w);
        end
    end else begin
      if (bus.ihit) hit_q <= hit_q + 32'd1;
      if (bus.flush) begin
        state_q <= IDLE;
        k_q     <= '0;
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++) begin
            valid_q[w][s] <= 1'b0;
            age_q[s][w]   <= AW'(w);
          end
      end else begin
        if (upd) begin
          for (int w = 0; w < WAYS; w++) begin
            if (AW'(w) == uway)
              age_q[uset][w] <= '0;
            else if (age_q[uset][w] < age_q[uset][uway])
              age_q[uset][w] <= age_q[uset][w] + AW'(1);
          end
        end
        unique case (state_q)
          IDLE: begin
            if (bus.imemREN && !hit) begin
              state_q <= FILL;
              base_q  <= bus.imemaddr & ~32'(BLKWORDS * 4 - 1);
              vic_q   <= vic;
              k_q     <= '0;
              miss_q  <= miss_q + 32'd1;
            end
          end
          FILL: begin
            if (!bus.iwait) k_q <= k_q + KW'(1);
            if (last) begin
              valid_q[vic_q][fidx] <= 1'b1;
              state_q <= IDLE;
              k_q     <= '0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Line storage; written word by word during a refill.
  always_ff @(posedge CLK) begin
    if (state_q == FILL && !bus.iwait && !bus.flush) begin
      data_q[vic_q][fidx][k_q] <= bus.iload;
      tag_q[vic_q][fidx]       <= ftag;
    end
  end
endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc: vector table of fetches
// plus wait-state, flush and reset sequences.
module tb_icache_assoc;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_assoc_if bus();

  icache_assoc #(.WAYS(2), .SETS(8), .BLKWORDS(2)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int ws = 0;
  int wcnt = 0;
  int exp_hits = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'hAAAA0000 + (a >> 2) - 32'd15;
  endfunction

  assign bus.iload = mem(bus.iaddr);

  // Memory model: ws busy cycles before each accepted word.
  always @(negedge clk) begin
    if (!bus.iREN) begin
      bus.iwait = 1'b0;
      wcnt = 0;
    end else if (wcnt < ws) begin
      bus.iwait = 1'b1;
      wcnt++;
    end else begin
      bus.iwait = 1'b0;
      wcnt = 0;
    end
  end

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a, output int lat,
                       output logic [31:0] d);
    bus.imemaddr = a;
    bus.imemREN  = 1'b1;
    lat = 0;
    #1;
    while (!bus.ihit && lat < 100) begin
      @(posedge clk);
      #2;
      lat++;
    end
    d = bus.imemload;
  endtask

  typedef struct {
    logic [31:0] addr;
    int          ws;
    int          lat;
    logic [31:0] data;
    logic [31:0] miss;
  } vec_t;

  vec_t v[10];
  int lat;
  logic [31:0] d;

  initial begin
    v[0] = '{32'h040, 0, 3,  32'hAAAA0001, 1};
    v[1] = '{32'h044, 0, 0,  32'hAAAA0002, 1};
    v[2] = '{32'h000, 0, 3,  32'hAAA9FFF1, 2};
    v[3] = '{32'h000, 0, 0,  32'hAAA9FFF1, 2};
    v[4] = '{32'h080, 0, 3,  32'hAAAA0011, 3};
    v[5] = '{32'h000, 0, 0,  32'hAAA9FFF1, 3};
    v[6] = '{32'h040, 0, 3,  32'hAAAA0001, 4};
    v[7] = '{32'h004, 0, 0,  32'hAAA9FFF2, 4};
    v[8] = '{32'h100, 5, 13, 32'hAAAA0031, 5};
    v[9] = '{32'h104, 0, 0,  32'hAAAA0032, 5};

    rst = 1'b1;
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h040;
    bus.flush    = 1'b0;
    #12;
    chk("rst_ihit", 32'(bus.ihit), 0);
    chk("rst_load", bus.imemload, 0);
    chk("rst_iren", 32'(bus.iREN), 0);
    chk("rst_hits", bus.hit_count, 0);
    chk("rst_miss", bus.miss_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      ws = v[i].ws;
      fetch(v[i].addr, lat, d);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(v[i].lat));
      chk($sformatf("v%0d_data", i), d, v[i].data);
      chk($sformatf("v%0d_miss", i), bus.miss_count, v[i].miss);
      step();
      bus.imemREN = 1'b0;
      exp_hits++;
      #1;
      chk($sformatf("v%0d_hits", i), bus.hit_count, 32'(exp_hits));
      chk($sformatf("v%0d_iren", i), 32'(bus.iREN), 0);
    end

    // Wait states: iaddr held per word.
    ws = 5;
    bus.imemaddr = 32'h148;
    bus.imemREN  = 1'b1;
    #1;
    chk("ws_idle_iren", 32'(bus.iREN), 0);
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #2;
      chk($sformatf("ws_c%0d_iren", c), 32'(bus.iREN), 1);
      chk($sformatf("ws_c%0d_iaddr", c), bus.iaddr,
          (c <= 6) ? 32'h148 : 32'h14C);
    end
    @(posedge clk);
    #2;
    chk("ws_hit", 32'(bus.ihit), 1);
    chk("ws_data", bus.imemload, 32'hAAAA0043);
    chk("ws_miss", bus.miss_count, 6);
    step();
    bus.imemREN = 1'b0;
    exp_hits++;
    ws = 0;

    // Flush after first refill word.
    bus.imemaddr = 32'h208;
    bus.imemREN  = 1'b1;
    step();
    #1;
    chk("fl_iren", 32'(bus.iREN), 1);
    chk("fl_iaddr0", bus.iaddr, 32'h208);
    step();
    bus.flush = 1'b1;
    #1;
    chk("fl_ihit", 32'(bus.ihit), 0);
    chk("fl_iaddr1", bus.iaddr, 32'h20C);
    step();
    bus.flush = 1'b0;
    #1;
    chk("fl_iren_drop", 32'(bus.iREN), 0);
    chk("fl_miss", bus.miss_count, 7);
    fetch(32'h208, lat, d);
    chk("fl_re_lat", 32'(lat), 3);
    chk("fl_re_data", d, 32'hAAAA0073);
    chk("fl_re_miss", bus.miss_count, 8);
    step();
    bus.imemREN = 1'b0;
    exp_hits++;

    // Flush over a valid line blocks the hit.
    bus.imemaddr = 32'h148;
    bus.imemREN  = 1'b1;
    bus.flush    = 1'b1;
    #1;
    chk("fh_ihit", 32'(bus.ihit), 0);
    step();
    bus.flush   = 1'b0;
    bus.imemREN = 1'b0;
    #1;
    chk("fh_hits", bus.hit_count, 32'(exp_hits));
    fetch(32'h040, lat, d);
    chk("fa_040_lat", 32'(lat), 3);
    chk("fa_040_data", d, 32'hAAAA0001);
    step();
    bus.imemREN = 1'b0;
    exp_hits++;
    fetch(32'h148, lat, d);
    chk("fa_148_lat", 32'(lat), 3);
    chk("fa_148_data", d, 32'hAAAA0043);
    chk("fa_miss", bus.miss_count, 10);
    step();
    bus.imemREN = 1'b0;
    exp_hits++;

    // Flush and miss in the same cycle.
    bus.imemaddr = 32'h300;
    bus.imemREN  = 1'b1;
    bus.flush    = 1'b1;
    #1;
    chk("fm_ihit", 32'(bus.ihit), 0);
    step();
    bus.flush   = 1'b0;
    bus.imemREN = 1'b0;
    #1;
    chk("fm_iren", 32'(bus.iREN), 0);
    chk("fm_miss", bus.miss_count, 10);
    chk("fm_hits", bus.hit_count, 32'(exp_hits));

    // Asynchronous reset mid-refill.
    ws = 3;
    bus.imemaddr = 32'h400;
    bus.imemREN  = 1'b1;
    step();
    step();
    #2;
    chk("rm_pre_iren", 32'(bus.iREN), 1);
    rst = 1'b1;
    #1;
    chk("rm_iren", 32'(bus.iREN), 0);
    chk("rm_ihit", 32'(bus.ihit), 0);
    chk("rm_hits", bus.hit_count, 0);
    chk("rm_miss", bus.miss_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ws = 0;
    fetch(32'h040, lat, d);
    chk("rm_lat", 32'(lat), 3);
    chk("rm_data", d, 32'hAAAA0001);
    chk("rm_miss1", bus.miss_count, 1);
    step();
    bus.imemREN = 1'b0;
    #1;
    chk("rm_hits1", bus.hit_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
